// File: rtl/axi_llc_miss_tracker.sv
// Outstanding-miss tracker for the LLC hit/miss stage.
// Per-ID and per-direction counters steer descriptors to the miss path.
module axi_llc_miss_tracker #(
    parameter int unsigned IdWidth        = 6,
    parameter int unsigned UseIdBits      = 2,
    parameter int unsigned CntWidth       = 4,
    parameter int unsigned WCntWidth      = 5,
    parameter int unsigned RCntWidth      = 5,
    parameter bit          WriteOrder     = 1'b1,
    parameter bit          ReadAfterWrite = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 up_valid_i,
    output logic                 up_ready_o,
    input  logic [IdWidth-1:0]   up_id_i,
    input  logic                 up_rw_i,
    input  logic                 down_valid_i,
    input  logic [IdWidth-1:0]   down_id_i,
    input  logic                 down_rw_i,
    output logic                 to_miss_o,
    output logic                 idle_o,
    output logic                 err_underflow_o,
    output logic [WCntWidth-1:0] w_cnt_o,
    output logic [RCntWidth-1:0] r_cnt_o
);

    localparam int unsigned NoCounters = 2 ** UseIdBits;

    logic [CntWidth-1:0]   r_cnt [NoCounters];
    logic [WCntWidth-1:0]  r_w_cnt;
    logic [RCntWidth-1:0]  r_r_cnt;
    logic                  r_err;

    logic [UseIdBits-1:0]  w_up_idx;
    logic [UseIdBits-1:0]  w_dn_idx;
    logic                  w_up_id_full;
    logic                  w_up_dir_full;
    logic                  w_up_fire;
    logic [NoCounters-1:0] w_id_inc;
    logic [NoCounters-1:0] w_id_dec;
    logic [NoCounters-1:0] w_id_uflow;
    logic [NoCounters-1:0] w_id_busy;
    logic [CntWidth-1:0]   w_cnt_nxt [NoCounters];
    logic                  w_w_inc;
    logic                  w_w_dec;
    logic                  w_r_inc;
    logic                  w_r_dec;
    logic [WCntWidth-1:0]  w_w_nxt;
    logic [RCntWidth-1:0]  w_r_nxt;
    logic                  w_w_uflow;
    logic                  w_r_uflow;
    logic                  w_unused_id;

    // Only the low ID bits select a counter; upper bits alias onto them.
    assign w_up_idx    = up_id_i[UseIdBits-1:0];
    assign w_dn_idx    = down_id_i[UseIdBits-1:0];
    assign w_unused_id = ^{up_id_i, down_id_i};

    // Ready depends on registered counts only, so a same-cycle down
    // cannot create a path from down_* to up_ready_o.
    assign w_up_id_full  = (r_cnt[w_up_idx] == '1);
    assign w_up_dir_full = up_rw_i ? (r_w_cnt == '1) : (r_r_cnt == '1);
    assign up_ready_o    = ~w_up_id_full & ~w_up_dir_full;
    assign w_up_fire     = up_valid_i & up_ready_o;

    // One-hot increment/decrement selects for the per-ID counters.
    always_comb begin
        w_id_inc = '0;
        w_id_dec = '0;
        if (w_up_fire) begin
            w_id_inc[w_up_idx] = 1'b1;
        end
        if (down_valid_i) begin
            w_id_dec[w_dn_idx] = 1'b1;
        end
    end

    // Per-ID next state: net-zero on inc+dec, saturate at 0 on underflow.
    always_comb begin
        for (int i = 0; i < NoCounters; i++) begin
            w_cnt_nxt[i]  = r_cnt[i];
            w_id_uflow[i] = 1'b0;
            if (w_id_inc[i] && !w_id_dec[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end else if (w_id_dec[i] && !w_id_inc[i]) begin
                if (r_cnt[i] == '0) begin
                    w_id_uflow[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign w_w_inc = w_up_fire & up_rw_i;
    assign w_r_inc = w_up_fire & ~up_rw_i;
    assign w_w_dec = down_valid_i & down_rw_i;
    assign w_r_dec = down_valid_i & ~down_rw_i;

    // Write direction counter next state.
    always_comb begin
        w_w_nxt   = r_w_cnt;
        w_w_uflow = 1'b0;
        if (w_w_inc && !w_w_dec) begin
            w_w_nxt = r_w_cnt + 1'b1;
        end else if (w_w_dec && !w_w_inc) begin
            if (r_w_cnt == '0) begin
                w_w_uflow = 1'b1;
            end else begin
                w_w_nxt = r_w_cnt - 1'b1;
            end
        end
    end

    // Read direction counter next state.
    always_comb begin
        w_r_nxt   = r_r_cnt;
        w_r_uflow = 1'b0;
        if (w_r_inc && !w_r_dec) begin
            w_r_nxt = r_r_cnt + 1'b1;
        end else if (w_r_dec && !w_r_inc) begin
            if (r_r_cnt == '0) begin
                w_r_uflow = 1'b1;
            end else begin
                w_r_nxt = r_r_cnt - 1'b1;
            end
        end
    end

    // Register all counters and the sticky underflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NoCounters; i++) begin
                r_cnt[i] <= '0;
            end
            r_w_cnt <= '0;
            r_r_cnt <= '0;
            r_err   <= 1'b0;
        end else begin
            for (int i = 0; i < NoCounters; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_w_cnt <= w_w_nxt;
            r_r_cnt <= w_r_nxt;
            if ((|w_id_uflow) || w_w_uflow || w_r_uflow) begin
                r_err <= 1'b1;
            end
        end
    end

    // Busy map of per-ID counters for the idle indication.
    always_comb begin
        for (int i = 0; i < NoCounters; i++) begin
            w_id_busy[i] = (r_cnt[i] != '0);
        end
    end

    // Miss routing is conservative: registered counts only.
    assign to_miss_o = (r_cnt[w_up_idx] != '0)
                     | (WriteOrder & up_rw_i & (r_w_cnt != '0))
                     | (ReadAfterWrite & ~up_rw_i & (r_w_cnt != '0));

    assign idle_o          = ~(|w_id_busy) & (r_w_cnt == '0) & (r_r_cnt == '0);
    assign err_underflow_o = r_err;
    assign w_cnt_o         = r_w_cnt;
    assign r_cnt_o         = r_r_cnt;

endmodule

// File: tb/tb_axi_llc_miss_tracker.sv
// Directed bench for axi_llc_miss_tracker.
// Second instance uses ReadAfterWrite=1 on shared stimulus.
module tb_axi_llc_miss_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       up_valid;
    logic [5:0] up_id;
    logic       up_rw;
    logic       dn_valid;
    logic [5:0] dn_id;
    logic       dn_rw;

    logic       ready, miss, idle, err;
    logic [4:0] wcnt, rcnt;
    logic       ready2, miss2, idle2, err2;
    logic [4:0] wcnt2, rcnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi_llc_miss_tracker dut (
        .clk_i(clk), .rst_i(rst),
        .up_valid_i(up_valid), .up_ready_o(ready),
        .up_id_i(up_id), .up_rw_i(up_rw),
        .down_valid_i(dn_valid), .down_id_i(dn_id),
        .down_rw_i(dn_rw),
        .to_miss_o(miss), .idle_o(idle),
        .err_underflow_o(err),
        .w_cnt_o(wcnt), .r_cnt_o(rcnt)
    );

    axi_llc_miss_tracker #(.ReadAfterWrite(1'b1)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .up_valid_i(up_valid), .up_ready_o(ready2),
        .up_id_i(up_id), .up_rw_i(up_rw),
        .down_valid_i(dn_valid), .down_id_i(dn_id),
        .down_rw_i(dn_rw),
        .to_miss_o(miss2), .idle_o(idle2),
        .err_underflow_o(err2),
        .w_cnt_o(wcnt2), .r_cnt_o(rcnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_up(input logic v, input logic [5:0] id, input logic rw);
        up_valid = v;
        up_id    = id;
        up_rw    = rw;
        #1;
    endtask

    task automatic set_dn(input logic v, input logic [5:0] id, input logic rw);
        dn_valid = v;
        dn_id    = id;
        dn_rw    = rw;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_up(1'b0, 6'd0, 1'b0);
        set_dn(1'b0, 6'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (idle !== 1'b1) begin
            n_errors++; $display("FAIL reset_idle: got %b expected 1", idle);
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready: got %b expected 1", ready);
        end
        n_checks++;
        if (wcnt !== 5'd0 || rcnt !== 5'd0) begin
            n_errors++; $display("FAIL reset_cnt: got w=%0d r=%0d expected 0 0", wcnt, rcnt);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++; $display("FAIL reset_err: got %b expected 0", err);
        end
        set_up(1'b1, 6'd3, 1'b1);
        n_checks++;
        if (miss !== 1'b0 || miss2 !== 1'b0) begin
            n_errors++; $display("FAIL reset_miss: got %b/%b expected 0/0", miss, miss2);
        end
        set_up(1'b0, 6'd0, 1'b0);
    endtask

    task automatic test_id_order();
        set_up(1'b1, 6'h05, 1'b0);
        tick();
        set_up(1'b0, 6'h05, 1'b0);
        n_checks++;
        if (rcnt !== 5'd1 || idle !== 1'b0) begin
            n_errors++; $display("FAIL id_count: got r=%0d idle=%b expected 1 0", rcnt, idle);
        end
        set_up(1'b1, 6'h01, 1'b0);
        n_checks++;
        if (miss !== 1'b1) begin
            n_errors++; $display("FAIL id_alias_miss: got %b expected 1", miss);
        end
        set_up(1'b1, 6'h02, 1'b0);
        n_checks++;
        if (miss !== 1'b0) begin
            n_errors++; $display("FAIL id_other_miss: got %b expected 0", miss);
        end
        set_up(1'b0, 6'h02, 1'b0);
        set_dn(1'b1, 6'h05, 1'b0);
        tick();
        set_dn(1'b0, 6'h00, 1'b0);
        set_up(1'b1, 6'h01, 1'b0);
        n_checks++;
        if (miss !== 1'b0 || idle !== 1'b1) begin
            n_errors++; $display("FAIL id_drained: got miss=%b idle=%b expected 0 1", miss, idle);
        end
        set_up(1'b0, 6'h00, 1'b0);
    endtask

    task automatic test_write_order();
        set_up(1'b1, 6'h00, 1'b1);
        tick();
        set_up(1'b1, 6'h03, 1'b1);
        n_checks++;
        if (miss !== 1'b1 || wcnt !== 5'd1) begin
            n_errors++; $display("FAIL wr_serial: got miss=%b w=%0d expected 1 1", miss, wcnt);
        end
        set_up(1'b1, 6'h03, 1'b0);
        n_checks++;
        if (miss !== 1'b0) begin
            n_errors++; $display("FAIL rd_past_wr: got %b expected 0", miss);
        end
        n_checks++;
        if (miss2 !== 1'b1) begin
            n_errors++; $display("FAIL rd_after_wr: got %b expected 1", miss2);
        end
        set_up(1'b0, 6'h00, 1'b0);
        set_dn(1'b1, 6'h00, 1'b1);
        tick();
        set_dn(1'b0, 6'h00, 1'b0);
        n_checks++;
        if (idle !== 1'b1 || wcnt !== 5'd0) begin
            n_errors++; $display("FAIL wr_drained: got idle=%b w=%0d expected 1 0", idle, wcnt);
        end
    endtask

    task automatic test_saturation();
        set_up(1'b1, 6'h02, 1'b0);
        repeat (15) tick();
        n_checks++;
        if (rcnt !== 5'd15 || ready !== 1'b0) begin
            n_errors++; $display("FAIL sat_full: got r=%0d ready=%b expected 15 0", rcnt, ready);
        end
        set_up(1'b1, 6'h01, 1'b0);
        n_checks++;
        if (ready !== 1'b1) begin
            n_errors++; $display("FAIL sat_other_ready: got %b expected 1", ready);
        end
        set_up(1'b1, 6'h02, 1'b0);
        tick();
        n_checks++;
        if (rcnt !== 5'd15) begin
            n_errors++; $display("FAIL sat_held: got %0d expected 15", rcnt);
        end
        set_dn(1'b1, 6'h02, 1'b0);
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++; $display("FAIL sat_dn_no_ready: got %b expected 0", ready);
        end
        tick();
        set_dn(1'b0, 6'h00, 1'b0);
        n_checks++;
        if (rcnt !== 5'd14 || ready !== 1'b1) begin
            n_errors++; $display("FAIL sat_dn: got r=%0d ready=%b expected 14 1", rcnt, ready);
        end
        tick();
        set_up(1'b0, 6'h00, 1'b0);
        n_checks++;
        if (rcnt !== 5'd15) begin
            n_errors++; $display("FAIL sat_refill: got %0d expected 15", rcnt);
        end
        set_dn(1'b1, 6'h02, 1'b0);
        repeat (15) tick();
        set_dn(1'b0, 6'h00, 1'b0);
        n_checks++;
        if (idle !== 1'b1 || err !== 1'b0) begin
            n_errors++; $display("FAIL sat_drain: got idle=%b err=%b expected 1 0", idle, err);
        end
    endtask

    task automatic test_simultaneous();
        set_up(1'b1, 6'h01, 1'b1);
        repeat (3) tick();
        set_dn(1'b1, 6'h01, 1'b1);
        tick();
        set_up(1'b0, 6'h00, 1'b0);
        set_dn(1'b0, 6'h00, 1'b0);
        n_checks++;
        if (wcnt !== 5'd3 || rcnt !== 5'd0) begin
            n_errors++; $display("FAIL sim_same: got w=%0d r=%0d expected 3 0", wcnt, rcnt);
        end
        set_up(1'b1, 6'h01, 1'b0);
        set_dn(1'b1, 6'h01, 1'b1);
        tick();
        set_up(1'b0, 6'h00, 1'b0);
        set_dn(1'b0, 6'h00, 1'b0);
        n_checks++;
        if (wcnt !== 5'd2 || rcnt !== 5'd1) begin
            n_errors++; $display("FAIL sim_mixed: got w=%0d r=%0d expected 2 1", wcnt, rcnt);
        end
        set_dn(1'b1, 6'h01, 1'b0);
        tick();
        set_dn(1'b1, 6'h01, 1'b1);
        repeat (2) tick();
        set_dn(1'b0, 6'h00, 1'b0);
        n_checks++;
        if (idle !== 1'b1 || err !== 1'b0) begin
            n_errors++; $display("FAIL sim_drain: got idle=%b err=%b expected 1 0", idle, err);
        end
    endtask

    task automatic test_underflow();
        set_dn(1'b1, 6'h01, 1'b0);
        tick();
        set_dn(1'b0, 6'h00, 1'b0);
        n_checks++;
        if (err !== 1'b1 || rcnt !== 5'd0 || idle !== 1'b1) begin
            n_errors++; $display("FAIL uflow: got err=%b r=%0d idle=%b expected 1 0 1", err, rcnt, idle);
        end
        set_up(1'b1, 6'h00, 1'b0);
        tick();
        set_up(1'b0, 6'h00, 1'b0);
        set_dn(1'b1, 6'h00, 1'b0);
        tick();
        set_dn(1'b0, 6'h00, 1'b0);
        n_checks++;
        if (err !== 1'b1 || idle !== 1'b1) begin
            n_errors++; $display("FAIL uflow_sticky: got err=%b idle=%b expected 1 1", err, idle);
        end
        do_reset();
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++; $display("FAIL uflow_clear: got %b expected 0", err);
        end
    endtask

    initial begin
        rst      = 1'b1;
        up_valid = 1'b0;
        up_id    = '0;
        up_rw    = 1'b0;
        dn_valid = 1'b0;
        dn_id    = '0;
        dn_rw    = 1'b0;
        test_reset();
        test_id_order();
        test_write_order();
        test_saturation();
        test_simultaneous();
        test_underflow();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
